// File: rtl/dc_fifo_wr_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dc_fifo_wr_arbiter_if                                        |
// | Description : Packet-source / FIFO-write bundle for dc_fifo_wr_arbiter.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface dc_fifo_wr_arbiter_if #(
    parameter int WIDTH  = 16,
    parameter int NREQ   = 4,
    parameter int WIDTHU = 4,
    parameter int LENW   = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*LENW-1:0]  len;
    logic [NREQ*WIDTH-1:0] data;
    logic [WIDTHU-1:0]     wrused;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       take;
    logic                  last;
    logic [NREQ-1:0]       reject;
    logic                  fifo_wren;
    logic [WIDTH-1:0]      fifo_data;
    logic                  busy;

    modport master (
        output req, len, data, wrused,
        input  grant, take, last, reject, fifo_wren, fifo_data, busy
    );

    modport slave (
        input  req, len, data, wrused,
        output grant, take, last, reject, fifo_wren, fifo_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/dc_fifo_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dc_fifo_wr_arbiter                                           |
// | Description : Round-robin whole-packet arbiter for one dc_fifo write port; |
// |               admits a packet only when the FIFO can hold all of it.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module dc_fifo_wr_arbiter #(
    parameter int WIDTH  = 16,
    parameter int NREQ   = 4,
    parameter int WIDTHU = 4,
    parameter int LENW   = 4
) (
    input  wire                  wrclk,
    input  wire                  resetn,
    dc_fifo_wr_arbiter_if.slave  bus
);
    localparam int               c_IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int               c_SW      = ((LENW > WIDTHU) ? LENW : WIDTHU) + 2;
    localparam logic [c_SW-1:0]  c_ONE     = c_SW'(1);
    localparam logic [c_SW-1:0]  c_CAP     = c_ONE << (WIDTHU - 1);
    localparam logic [NREQ-1:0]  c_ONEHOT0 = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [c_IW-1:0]   r_rr_last, w_rr_nxt;
    logic [c_IW-1:0]   r_owner, w_owner_nxt;
    logic [LENW-1:0]   r_cnt, w_cnt_nxt;
    logic              r_gap, w_gap_nxt;
    logic [NREQ-1:0]   r_grant, w_grant_nxt;
    logic [NREQ-1:0]   r_take, w_take_nxt;
    logic              r_last, w_last_nxt;
    logic [NREQ-1:0]   r_reject, w_reject_nxt;
    logic              r_busy;
    logic              r_fifo_wren;
    logic [WIDTH-1:0]  r_fifo_data;

    logic [NREQ-1:0]   w_req_eff;
    logic              w_found;
    logic [c_IW-1:0]   w_win;
    logic [c_IW-1:0]   w_cand;
    logic [NREQ-1:0]   w_win_1h;
    logic [LENW-1:0]   w_len_win;
    logic [WIDTH-1:0]  w_own_data;
    logic              w_oversize;
    logic              w_fits;

    // A requester is still high during its own reject pulse; masking it stops a double reject.
    always_comb begin
        w_req_eff  = bus.req & ~r_reject;
        w_found    = 1'b0;
        w_win      = r_rr_last;
        w_cand     = r_rr_last;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = c_IW'((int'(r_rr_last) + k) % NREQ);
            if (!w_found && w_req_eff[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
        w_win_1h   = c_ONEHOT0 << w_win;
        w_len_win  = '0;
        w_own_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == c_IW'(i)) begin
                w_len_win = bus.len[i*LENW +: LENW];
            end
            if (r_owner == c_IW'(i)) begin
                w_own_data = bus.data[i*WIDTH +: WIDTH];
            end
        end
        w_oversize = (c_SW'(w_len_win) + c_ONE) > c_CAP;
        w_fits     = (c_SW'(bus.wrused) + c_SW'(w_len_win) + c_ONE) <= c_CAP;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_nxt     = r_rr_last;
        w_owner_nxt  = r_owner;
        w_cnt_nxt    = r_cnt;
        w_gap_nxt    = r_gap;
        w_grant_nxt  = r_grant;
        w_take_nxt   = r_take;
        w_last_nxt   = 1'b0;
        w_reject_nxt = '0;
        case (r_state)
            S_IDLE: begin
                w_grant_nxt = '0;
                w_take_nxt  = '0;
                if (w_found) begin
                    if (w_oversize) begin
                        w_reject_nxt = w_win_1h;
                        w_rr_nxt     = w_win;
                    end else if (w_fits) begin
                        w_state_nxt = S_BURST;
                        w_cnt_nxt   = w_len_win;
                        w_owner_nxt = w_win;
                        w_grant_nxt = w_win_1h;
                        w_take_nxt  = w_win_1h;
                        w_last_nxt  = (w_len_win == '0);
                        w_rr_nxt    = w_win;
                    end
                end
            end
            S_BURST: begin
                // r_cnt counts the takes still to come after the current one.
                if (r_cnt == '0) begin
                    w_state_nxt = S_GAP;
                    w_grant_nxt = '0;
                    w_take_nxt  = '0;
                    w_gap_nxt   = 1'b0;
                end else begin
                    w_cnt_nxt  = r_cnt - LENW'(1);
                    w_last_nxt = (r_cnt == LENW'(1));
                end
            end
            S_GAP: begin
                w_grant_nxt = '0;
                w_take_nxt  = '0;
                if (r_gap) begin
                    w_state_nxt = S_IDLE;
                    w_gap_nxt   = 1'b0;
                end else begin
                    w_gap_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_take_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge wrclk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_rr_last   <= c_IW'(NREQ - 1);
            r_owner     <= '0;
            r_cnt       <= '0;
            r_gap       <= 1'b0;
            r_grant     <= '0;
            r_take      <= '0;
            r_last      <= 1'b0;
            r_reject    <= '0;
            r_busy      <= 1'b0;
            r_fifo_wren <= 1'b0;
            r_fifo_data <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_last   <= w_rr_nxt;
            r_owner     <= w_owner_nxt;
            r_cnt       <= w_cnt_nxt;
            r_gap       <= w_gap_nxt;
            r_grant     <= w_grant_nxt;
            r_take      <= w_take_nxt;
            r_last      <= w_last_nxt;
            r_reject    <= w_reject_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_fifo_wren <= |r_take;
            if (|r_take) begin
                r_fifo_data <= w_own_data;
            end
        end
    end

    assign bus.grant     = r_grant;
    assign bus.take      = r_take;
    assign bus.last      = r_last;
    assign bus.reject    = r_reject;
    assign bus.busy      = r_busy;
    assign bus.fifo_wren = r_fifo_wren;
    assign bus.fifo_data = r_fifo_data;
endmodule
`default_nettype wire

// File: tb/tb_dc_fifo_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dc_fifo_wr_arbiter                                        |
// | Description : Timeline-model bench for dc_fifo_wr_arbiter.                 |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_dc_fifo_wr_arbiter;
    localparam int WIDTH  = 16;
    localparam int NREQ   = 4;
    localparam int WIDTHU = 4;
    localparam int LENW   = 4;
    localparam int CAP    = 8;

    logic wrclk  = 1'b0;
    logic resetn = 1'b0;

    dc_fifo_wr_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .WIDTHU(WIDTHU), .LENW(LENW)) bus ();

    dc_fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .WIDTHU(WIDTHU), .LENW(LENW)) dut (
        .wrclk  (wrclk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 wrclk = ~wrclk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Stimulus state: requesters and a simple FIFO occupancy model
    logic [NREQ-1:0] req_v;
    int  len_v[NREQ];
    int  seq[NREQ];
    int  hold_off[NREQ];
    int  fcount;
    int  peak;
    bit  rd_en;
    bit  rand_mode;

    // Timeline model: a granted packet occupies cycles m_start..m_end, then two gap cycles
    bit  m_valid;
    int  m_owner, m_start, m_end, m_rr;
    int  e_rej;
    bit  e_wren;
    logic [WIDTH-1:0] e_data;

    logic [NREQ-1:0]  s_grant, s_take, s_reject, prev_grant;
    logic             s_last, s_busy, s_wren;
    logic [WIDTH-1:0] s_data;
    int gq[$];
    int gcyc[$];

    function automatic logic [WIDTH-1:0] word(int i, int s);
        return WIDTH'((i << 12) | (s & 32'hfff));
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        bus.req = req_v;
        for (int i = 0; i < NREQ; i++) begin
            bus.len[i*LENW +: LENW]    = LENW'(len_v[i]);
            bus.data[i*WIDTH +: WIDTH] = word(i, seq[i]);
        end
        bus.wrused = WIDTHU'(fcount);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_rr    = NREQ - 1;
        e_rej   = -1;
        e_wren  = 1'b0;
        e_data  = '0;
        fcount  = 0;
        req_v   = '0;
    endtask

    task automatic compare();
        logic [NREQ-1:0] exp_take;
        bit in_burst;
        in_burst = m_valid && cyc >= m_start && cyc <= m_end;
        exp_take = in_burst ? (NREQ'(1) << m_owner) : '0;
        chk("grant", bus.grant, exp_take);
        chk("take", bus.take, exp_take);
        chk("last", bus.last, in_burst && cyc == m_end);
        chk("reject", bus.reject, (e_rej >= 0) ? (NREQ'(1) << e_rej) : '0);
        chk("busy", bus.busy, m_valid && cyc >= m_start && cyc <= m_end + 2);
        chk("fifo_wren", bus.fifo_wren, e_wren);
        if (e_wren) chk("fifo_data", bus.fifo_data, e_data);
        chk("wren_while_full", bus.fifo_wren & bus.wrused[WIDTHU-1], 0);
    endtask

    task automatic advance();
        int  w, n_rej;
        bit  n_wren;
        logic [WIDTH-1:0] n_data;
        if (!resetn) begin
            model_reset();
            return;
        end
        n_wren = m_valid && cyc >= m_start && cyc <= m_end;
        n_data = n_wren ? word(m_owner, seq[m_owner]) : '0;
        n_rej  = -1;
        if (!m_valid || cyc > m_end + 2) begin
            w = -1;
            for (int k = 1; k <= NREQ; k++) begin
                int i;
                i = (m_rr + k) % NREQ;
                if (w < 0 && req_v[i] && i != e_rej) w = i;
            end
            if (w >= 0) begin
                if (len_v[w] + 1 > CAP) begin
                    n_rej = w;
                    m_rr  = w;
                end else if (int'(bus.wrused) + len_v[w] + 1 <= CAP) begin
                    m_valid = 1'b1;
                    m_owner = w;
                    m_start = cyc + 1;
                    m_end   = cyc + 1 + len_v[w];
                    m_rr    = w;
                end
            end
        end
        e_wren = n_wren;
        e_data = n_data;
        e_rej  = n_rej;
        for (int i = 0; i < NREQ; i++) begin
            if (s_take[i]) seq[i]++;
            if ((s_take[i] && s_last) || s_reject[i]) begin
                req_v[i]    = 1'b0;
                hold_off[i] = $urandom_range(0, 3);
            end else if (rand_mode && !req_v[i]) begin
                if (hold_off[i] > 0) hold_off[i]--;
                else if ($urandom_range(0, 3) == 0) begin
                    req_v[i] = 1'b1;
                    len_v[i] = ($urandom_range(0, 15) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
                end
            end
        end
        if (s_wren) fcount++;
        if (rd_en && fcount > 0 && $urandom_range(0, 1) == 1) fcount--;
        if (fcount > peak) peak = fcount;
    endtask

    task automatic step();
        drive();
        @(negedge wrclk);
        compare();
        s_grant  = bus.grant;
        s_take   = bus.take;
        s_last   = bus.last;
        s_reject = bus.reject;
        s_busy   = bus.busy;
        s_wren   = bus.fifo_wren;
        s_data   = bus.fifo_data;
        if (prev_grant == '0 && s_grant != '0) begin
            for (int b = 0; b < NREQ; b++) if (s_grant[b]) gq.push_back(b);
            gcyc.push_back(cyc);
        end
        prev_grant = s_grant;
        @(posedge wrclk);
        #1;
        advance();
        cyc++;
        drive();
    endtask

    task automatic run(int n);
        for (int t = 0; t < n; t++) step();
    endtask

    logic [NREQ-1:0]  rec_g[10];
    logic             rec_last[10];
    logic             rec_busy[10];
    logic             rec_wren[10];
    logic [WIDTH-1:0] rec_data[10];

    initial begin
        int base, nbusy, nwren;
        bit reraised;
        for (int i = 0; i < NREQ; i++) begin
            len_v[i] = 0; seq[i] = 0; hold_off[i] = 0;
        end
        rd_en = 1'b0; rand_mode = 1'b0; peak = 0; prev_grant = '0;
        s_grant = '0; s_take = '0; s_reject = '0; s_last = 0; s_busy = 0; s_wren = 0; s_data = '0;
        model_reset();
        run(3);
        chk("reset_grant", s_grant, 0);
        chk("reset_busy", s_busy, 0);
        chk("reset_wren", s_wren, 0);
        resetn = 1'b1;
        run(2);

        // Rotation: 0 and 2 together, 0 re-raised after its packet
        gq.delete(); gcyc.delete();
        req_v[0] = 1'b1; len_v[0] = 0; req_v[2] = 1'b1; len_v[2] = 0;
        reraised = 1'b0;
        for (int t = 0; t < 16; t++) begin
            step();
            if (!reraised && !req_v[0]) begin
                req_v[0] = 1'b1; len_v[0] = 0; reraised = 1'b1;
            end
        end
        chk("rot_count", gq.size(), 3);
        if (gq.size() == 3) begin
            chk("rot_first", gq[0], 0);
            chk("rot_second", gq[1], 2);
            chk("rot_third", gq[2], 0);
            chk("rot_period1", gcyc[1] - gcyc[0], 4);
            chk("rot_period2", gcyc[2] - gcyc[1], 4);
        end

        // Single packet of four words from requester 0
        base = seq[0];
        req_v[0] = 1'b1; len_v[0] = 3;
        for (int t = 0; t < 10; t++) begin
            step();
            rec_g[t] = s_grant; rec_last[t] = s_last; rec_busy[t] = s_busy;
            rec_wren[t] = s_wren; rec_data[t] = s_data;
        end
        nbusy = 0; nwren = 0;
        for (int t = 0; t < 10; t++) begin
            nbusy += int'(rec_busy[t]);
            nwren += int'(rec_wren[t]);
        end
        chk("single_nogrant_t0", rec_g[0], 4'b0000);
        chk("single_grant_t1", rec_g[1], 4'b0001);
        chk("single_grant_t4", rec_g[4], 4'b0001);
        chk("single_grant_t5", rec_g[5], 4'b0000);
        chk("single_last_t3", rec_last[3], 0);
        chk("single_last_t4", rec_last[4], 1);
        chk("single_busy_cycles", nbusy, 6);
        chk("single_wren_cycles", nwren, 4);
        for (int j = 0; j < 4; j++) chk("single_word", rec_data[2 + j], word(0, base + j));

        // Space stall: wrused=6 blocks a 4-word packet until drained to 4
        fcount = 6; rd_en = 1'b0; peak = 6;
        req_v[1] = 1'b1; len_v[1] = 3;
        run(5);
        chk("stall_no_grant", s_grant, 0);
        fcount = 4;
        step();
        chk("stall_still_idle", s_grant, 0);
        step();
        chk("stall_grant", s_grant, 4'b0010);
        run(8);
        chk("stall_peak", peak, CAP);
        chk("stall_fill", fcount, CAP);

        // Oversize: rr_last preset to 2, then 3 (9 words) and 0 together
        fcount = 0;
        req_v[2] = 1'b1; len_v[2] = 0;
        run(6);
        req_v[3] = 1'b1; len_v[3] = 8; req_v[0] = 1'b1; len_v[0] = 0;
        step();
        step();
        chk("over_reject", s_reject, 4'b1000);
        chk("over_no_take", s_take, 0);
        step();
        chk("over_reject_once", s_reject, 0);
        chk("over_grant0", s_grant, 4'b0001);
        chk("over_no_wren", s_wren, 0);
        run(6);

        // Reset on the second take of a 6-word packet
        req_v[0] = 1'b1; len_v[0] = 5;
        step();
        step();
        chk("rst_second_take", bus.take, 4'b0001);
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        chk("rst_async_grant", bus.grant, 0);
        chk("rst_async_take", bus.take, 0);
        chk("rst_async_busy", bus.busy, 0);
        chk("rst_async_wren", bus.fifo_wren, 0);
        chk("rst_async_data", bus.fifo_data, 0);
        run(2);
        resetn = 1'b1;
        run(2);
        req_v[1] = 1'b1; len_v[1] = 1; req_v[2] = 1'b1; len_v[2] = 1;
        step();
        step();
        chk("rst_fresh_grant", s_grant, 4'b0010);
        run(12);

        // Saturation with random lengths and a random-rate reader
        rd_en = 1'b1; rand_mode = 1'b1; peak = 0;
        run(10000);
        rand_mode = 1'b0;
        run(120);
        chk("sat_peak", peak <= CAP, 1);
        chk("sat_idle", s_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/dc_fifo_wr_arbiter.md
# dc_fifo_wr_arbiter

Write-side arbiter that shares one `dc_fifo` write port among `NREQ` packet sources in the `wrclk` domain. It grants whole packets in round-robin order and admits a packet only when the FIFO has room for all of it, so the FIFO never sees a refused write. Oversize packets are rejected. The block sits between the per-source packet producers and the `data`/`wren`/`wrused` pins of a `dc_fifo` instance.

## Interface
- `WIDTH`, 16: data word width; equals the FIFO `WIDTH`.
- `NREQ`, 4: number of requesters, 2..16.
- `WIDTHU`, 4: FIFO `wrused` width. Usable capacity is `CAP = 2^(WIDTHU-1)` words.
- `LENW`, 4: packet length field width. Packet length in words is `len+1`.

- `resetn`: input, 1 bit. Reset is asynchronous and active-low.
- `wrclk`: input, 1 bit. All logic is clocked on its rising edge.
- `req`: input, NREQ bits. `req[i]` is requester i's packet request. It is held until `take`+`last` or `reject`.
- `len`: input, NREQ*LENW bits. Slice i holds requester i's length-1. It is stable while `req[i]` is high.
- `data`: input, NREQ*WIDTH bits. Slice i is requester i's current word (show-ahead). It advances after each `take[i]`.
- `wrused`: input, WIDTHU bits. Connects to FIFO `wrused`.
- `grant`: output, NREQ bits. One-hot owner during a burst.
- `take`: output, NREQ bits. Word-accepted strobe, one bit at most.
- `last`: output, 1 bit. Coincides with the final `take` of a packet.
- `reject`: output, NREQ bits. One-cycle pulse; the packet is not accepted.
- `fifo_wren`: output, 1 bit. Connects to FIFO `wren`.
- `fifo_data`: output, WIDTH bits. Connects to FIFO `data`.
- `busy`: output, 1 bit. High in BURST and GAP states.

## Operation
- Reset state: all outputs are 0, state is IDLE, and `rr_last` = NREQ-1.
- Round-robin arbitration:
  - The winner is the first `i` with `req[i]` high, searching from `rr_last+1` upward and wrapping mod NREQ.
  - Only one decision is made per IDLE cycle.
- In IDLE with a winner `w`, exactly one of three cases applies:
  - **Oversize** (`len_w+1 > CAP`): pulse `reject[w]` for 1 cycle, set `rr_last=w`, stay in IDLE.
  - **Fits** (`wrused + len_w + 1 <= CAP`, computed at WIDTHU+1 bits): go to BURST, load `cnt=len_w`, set `grant[w]`, set `rr_last=w`.
  - **Else**: stall in IDLE without skipping to another requester (head-of-line). `rr_last` is unchanged.
- BURST state:
  - `take[w]`=1 every cycle. `data_w` is registered into `fifo_data`, with `fifo_wren`=1 the following cycle.
  - `cnt` decrements each cycle. When `cnt`==0: `last`=1, and the next state is GAP.
  - Burst length is exactly `len_w+1` cycles, with no bubbles.
- GAP state: lasts 2 cycles. `grant` is 0 during GAP. This lets the pipelined final write land and `wrused` reflect it. Then go to IDLE.
- Requester obligation: drop `req[i]` on the cycle after `take[i]&last` or `reject[i]`. Otherwise the block treats the still-high `req[i]` as a new packet.
- FIFO reads only lower `wrused`, so the fit check is conservative. `fifo_wren` is never high while `wrused[WIDTHU-1]`=1.
- A `req` or `len` change from a non-granted requester during BURST has no effect.
- A reset mid-burst aborts immediately. Outputs return to their reset values. The partial packet is discarded, because the FIFO shares `resetn`.

## Timing
- Arbitration latency: `req` is sampled high in IDLE at edge E0. `grant` and the first `take` are high in the cycle after E0.
- Write latency: `fifo_wren` and `fifo_data` lag `take` by exactly 1 cycle.
- Packet occupancy: 1 arbitration cycle + `len+1` burst cycles + 2 gap cycles. The minimum back-to-back period is `len+4` cycles.
- `reject` costs 1 cycle. The next decision is made in the following cycle.
- `last`, `take`, `grant`, `reject`, `fifo_wren` and `busy` are all registered outputs.

## Test plan
All scenarios use WIDTH=16, NREQ=4, WIDTHU=4 (CAP=8), LENW=4.
- **Single packet:** `req[0]`=1, `len0`=3, words A0..A3, `wrused`=0.
  - `grant`=0001 and `take[0]` are high for 4 cycles starting 1 cycle after the request.
  - `last` is high on the 4th `take`.
  - `fifo_wren` is high for 4 cycles with data A0, A1, A2, A3, lagging by 1.
  - `busy` is high for 6 cycles.
- **Rotation:** `req[0]` and `req[2]` are raised together with `len`=0, and `req[0]` re-raises after its packet.
  - Grant order is 0, 2, 0.
  - Each packet occupies 4 cycles.
- **Space stall:** the FIFO model holds `wrused`=6, and `req[1]` is raised with `len`=3.
  - The block stays in IDLE with no `grant` and no `take`.
  - When the reader drains to `wrused`=4, `grant[1]` is high the following cycle.
  - The 4 words are written, and `wrused` never exceeds 8.
- **Oversize:** `req[3]` is raised with `len`=8 (9 words > CAP), while `req[0]` is raised with `len`=0.
  - With `rr_last` preset to 2, `reject[3]` pulses for 1 cycle with no `take` and no `fifo_wren`.
  - `req[0]` is then granted.
- **Reset mid-burst:** `resetn` is pulled low on the 2nd `take` of a `len`=5 packet.
  - All outputs go to 0 asynchronously.
  - After release, a fresh `req[1]` is granted first.
- **Saturation:** all 4 requesters loop random `len` values 0..7 against a random-rate reader for 10k cycles.
  - No `fifo_wren` occurs while `wrused[3]`=1.
  - The FIFO output sequence equals the per-source packets concatenated, with no interleaving.
